// File: rtl/seed_key_sched_ctrl.sv
// SEED key schedule sequencer: loads the user key, requests G for each of the
// 16 rounds from a shared G unit, and hands each round-key pair downstream.
// Optional feature: define SEED_KS_ABORT_EN to add the abort_i port.
module seed_key_sched_ctrl (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
`ifdef SEED_KS_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic         g_req_o,
    output logic [31:0]  g_in0_o,
    output logic [31:0]  g_in1_o,
    input  logic         g_ack_i,
    input  logic [31:0]  g_out0_i,
    input  logic [31:0]  g_out1_i,
    output logic         rk_valid_o,
    output logic [31:0]  rk0_o,
    output logic [31:0]  rk1_o,
    output logic [3:0]   rk_round_o,
    input  logic         rk_ready_i
);

    localparam logic [31:0] Kc0 = 32'h9E3779B9;

    typedef enum logic [1:0] {StIdle, StGreq, StOut} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [31:0] kc_q, kc_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] rk0_q, rk0_d, rk1_q, rk1_d;
    logic        busy_q, done_q, done_d, g_req_q, rk_valid_q;

    // G arguments are pure functions of the key words, so they hold while waiting for g_ack.
    assign g_in0_o = a_q + c_q - kc_q;
    assign g_in1_o = b_q - d_q + kc_q;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign g_req_o    = g_req_q;
    assign rk_valid_o = rk_valid_q;
    assign rk0_o      = rk0_q;
    assign rk1_o      = rk1_q;
    assign rk_round_o = round_q;

    // Next-state logic: key load, G capture, and between-round word rotations.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        kc_d    = kc_q;
        round_d = round_q;
        rk0_d   = rk0_q;
        rk1_d   = rk1_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = key_i[127:96];
                    b_d     = key_i[95:64];
                    c_d     = key_i[63:32];
                    d_d     = key_i[31:0];
                    kc_d    = Kc0;
                    round_d = 4'd0;
                    state_d = StGreq;
                end
            end
            StGreq: begin
                if (g_ack_i) begin
                    rk0_d   = g_out0_i;
                    rk1_d   = g_out1_i;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (rk_ready_i) begin
                    if (round_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // Even rounds rotate A||B right by 8, odd rounds rotate C||D left by 8.
                        if (!round_q[0]) begin
                            {a_d, b_d} = {b_q[7:0], a_q, b_q[31:8]};
                        end else begin
                            {c_d, d_d} = {c_q[23:0], d_q, c_q[31:24]};
                        end
                        kc_d    = {kc_q[30:0], kc_q[31]};
                        round_d = round_q + 4'd1;
                        state_d = StGreq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SEED_KS_ABORT_EN
        // Abort wins over any handshake this cycle; key words and round are left as they were.
        if (abort_i && (state_q != StIdle)) begin
            a_d     = a_q;
            b_d     = b_q;
            c_d     = c_q;
            d_d     = d_q;
            kc_d    = kc_q;
            round_d = round_q;
            rk0_d   = rk0_q;
            rk1_d   = rk1_q;
            done_d  = 1'b0;
            state_d = StIdle;
        end
`endif
    end

    // State and registered status outputs, all derived from the next state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            kc_q       <= '0;
            round_q    <= '0;
            rk0_q      <= '0;
            rk1_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            g_req_q    <= 1'b0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            kc_q       <= kc_d;
            round_q    <= round_d;
            rk0_q      <= rk0_d;
            rk1_q      <= rk1_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= done_d;
            g_req_q    <= (state_d == StGreq);
            rk_valid_q <= (state_d == StOut);
        end
    end

endmodule

// File: tb/tb_seed_key_sched_ctrl.sv
// Self-checking bench for seed_key_sched_ctrl. A reference key-schedule model
// predicts each round's G arguments; the G unit echoes its inputs.
module tb_seed_key_sched_ctrl;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
`ifdef SEED_KS_ABORT_EN
    logic         abort_i = 1'b0;
`endif
    logic         busy_o, done_o, g_req_o, rk_valid_o;
    logic [31:0]  g_in0_o, g_in1_o, rk0_o, rk1_o;
    logic [3:0]   rk_round_o;
    logic         g_ack_i = 1'b0;
    logic [31:0]  g_out0_i = '0, g_out1_i = '0;
    logic         rk_ready_i = 1'b0;

    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] k0;
        logic [31:0] k1;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] obs_gi0 [16];
    logic [31:0] obs_gi1 [16];

    seed_key_sched_ctrl u_dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .key_i      (key_i),
`ifdef SEED_KS_ABORT_EN
        .abort_i    (abort_i),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .g_req_o    (g_req_o),
        .g_in0_o    (g_in0_o),
        .g_in1_o    (g_in1_o),
        .g_ack_i    (g_ack_i),
        .g_out0_i   (g_out0_i),
        .g_out1_i   (g_out1_i),
        .rk_valid_o (rk_valid_o),
        .rk0_o      (rk0_o),
        .rk1_o      (rk1_o),
        .rk_round_o (rk_round_o),
        .rk_ready_i (rk_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_o) done_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_g_req", g_req_o, 1'b0);
        check_eq("rst_rk_valid", rk_valid_o, 1'b0);
        check_eq("rst_g_in0", g_in0_o, 32'h0);
        check_eq("rst_g_in1", g_in1_o, 32'h0);
        check_eq("rst_rk0", rk0_o, 32'h0);
        check_eq("rst_rk1", rk1_o, 32'h0);
        check_eq("rst_rk_round", rk_round_o, 4'h0);
    endtask

    // Runs one schedule; rst_round/abort_round < 0 disable those interruptions.
    task automatic run_sched(input logic [127:0] k, input int gdly, input int rdly,
                             input int rst_round, input int abort_round, input bit spur);
        logic [31:0] ma, mb, mc, md, mkc, gi0, gi1;
        logic [63:0] t;
        exp_t        e;
        ma  = k[127:96];
        mb  = k[95:64];
        mc  = k[63:32];
        md  = k[31:0];
        mkc = 32'h9E3779B9;
        start_i = 1'b1;
        key_i   = k;
        tick();
        start_i = 1'b0;
        key_i   = ~k;
        for (int r = 0; r < 16; r++) begin
            gi0 = ma + mc - mkc;
            gi1 = mb - md + mkc;
            obs_gi0[r] = g_in0_o;
            obs_gi1[r] = g_in1_o;
            check_eq("g_req", g_req_o, 1'b1);
            check_eq("busy", busy_o, 1'b1);
            check_eq("rk_valid_in_greq", rk_valid_o, 1'b0);
            check_eq("g_in0", g_in0_o, gi0);
            check_eq("g_in1", g_in1_o, gi1);
            for (int i = 0; i < gdly; i++) begin
                if (spur && i == 0) start_i = 1'b1;
                tick();
                start_i = 1'b0;
                check_eq("g_req_hold", g_req_o, 1'b1);
                check_eq("g_in0_hold", g_in0_o, gi0);
                check_eq("g_in1_hold", g_in1_o, gi1);
                check_eq("rk_valid_wait", rk_valid_o, 1'b0);
            end
`ifdef SEED_KS_ABORT_EN
            if (r == abort_round) begin
                abort_i  = 1'b1;
                g_ack_i  = 1'b1;
                g_out0_i = g_in0_o;
                g_out1_i = g_in1_o;
                tick();
                abort_i = 1'b0;
                g_ack_i = 1'b0;
                check_eq("abort_busy", busy_o, 1'b0);
                check_eq("abort_g_req", g_req_o, 1'b0);
                check_eq("abort_rk_valid", rk_valid_o, 1'b0);
                check_eq("abort_done", done_o, 1'b0);
                tick();
                check_eq("abort_rk_valid2", rk_valid_o, 1'b0);
                check_eq("abort_done2", done_o, 1'b0);
                return;
            end
`endif
            g_ack_i  = 1'b1;
            g_out0_i = g_in0_o;
            g_out1_i = g_in1_o;
            sb.push_back('{r: r[3:0], k0: gi0, k1: gi1});
            tick();
            g_ack_i  = 1'b0;
            g_out0_i = '0;
            g_out1_i = '0;
            check_eq("rk_valid", rk_valid_o, 1'b1);
            check_eq("g_req_in_out", g_req_o, 1'b0);
            if (r == rst_round) begin
                reset_i = 1'b1;
                #1;
                check_reset_outputs();
                tick();
                reset_i = 1'b0;
                sb.delete();
                return;
            end
            for (int i = 0; i < rdly; i++) begin
                if (spur && i == 0) begin
                    g_ack_i  = 1'b1;
                    g_out0_i = 32'hDEADBEEF;
                    g_out1_i = 32'h0BADF00D;
                end
                tick();
                g_ack_i = 1'b0;
                check_eq("rk_valid_hold", rk_valid_o, 1'b1);
                check_eq("rk0_hold", rk0_o, gi0);
                check_eq("rk1_hold", rk1_o, gi1);
                check_eq("rk_round_hold", rk_round_o, r[3:0]);
            end
            rk_ready_i = 1'b1;
            check_eq("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("rk0", rk0_o, e.k0);
                check_eq("rk1", rk1_o, e.k1);
                check_eq("rk_round", rk_round_o, e.r);
            end
            tick();
            rk_ready_i = 1'b0;
            if (r[0] == 1'b0) begin
                t = {ma, mb};
                t = {t[7:0], t[63:8]};
                {ma, mb} = t;
            end else begin
                t = {mc, md};
                t = {t[55:0], t[63:56]};
                {mc, md} = t;
            end
            mkc = {mkc[30:0], mkc[31]};
            if (r == 15) begin
                check_eq("done_pulse", done_o, 1'b1);
                check_eq("busy_on_done", busy_o, 1'b0);
                check_eq("rk_valid_on_done", rk_valid_o, 1'b0);
            end else begin
                check_eq("no_early_done", done_o, 1'b0);
            end
        end
        tick();
        check_eq("done_one_cycle", done_o, 1'b0);
        check_eq("idle_g_req", g_req_o, 1'b0);
    endtask

    initial begin
        int dc;
        #2;
        check_reset_outputs();
        tick();
        reset_i = 1'b0;
        tick();
        check_reset_outputs();

        // Zero key, zero-wait G and downstream.
        dc = done_cnt;
        run_sched(128'h0, 0, 0, -1, -1, 1'b0);
        check_eq("zero_kat_gin0", obs_gi0[0], 32'h61C88647);
        check_eq("zero_kat_gin1", obs_gi1[0], 32'h9E3779B9);
        check_eq("zero_done_count", done_cnt - dc, 1);

        // Known key with backpressure and spurious start/g_ack pulses.
        dc = done_cnt;
        run_sched(128'h00112233_44556677_8899AABB_CCDDEEFF, 5, 3, -1, -1, 1'b1);
        check_eq("kat_r0_gin0", obs_gi0[0], 32'hEA735335);
        check_eq("kat_r0_gin1", obs_gi1[0], 32'h15AEF131);
        check_eq("kat_r1_gin0", obs_gi0[1], 32'hC32AC86A);
        check_eq("kat_r1_gin1", obs_gi1[1], 32'hA2D559DA);
        check_eq("kat_done_count", done_cnt - dc, 1);

        // Reset in round 7 OUT, then a clean restart from round 0.
        dc = done_cnt;
        run_sched(128'h0123456789ABCDEF_FEDCBA9876543210, 1, 1, 7, -1, 1'b0);
        check_reset_outputs();
        check_eq("rst_no_done", done_cnt - dc, 0);
        dc = done_cnt;
        run_sched(128'h0123456789ABCDEF_FEDCBA9876543210, 0, 2, -1, -1, 1'b0);
        check_eq("restart_done_count", done_cnt - dc, 1);

`ifdef SEED_KS_ABORT_EN
        dc = done_cnt;
        run_sched(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 0, 0, -1, 3, 1'b0);
        check_eq("abort_no_done", done_cnt - dc, 0);
        dc = done_cnt;
        run_sched(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 1, 0, -1, -1, 1'b0);
        check_eq("post_abort_done_count", done_cnt - dc, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
